// File: rtl/inst_queue_pkg.sv
// Shared IF->ID types for the fetch/decode boundary.
// The entry struct is reused by other pipeline blocks that carry fetched words.
package inst_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        adel;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INS = 32'h0;

  // Entry presented to decode when the queue is empty: decodes as a NOP.
  localparam fetch_entry_t NOP_ENTRY = '{pc: 32'h0, ins: NOP_INS, adel: 1'b0};

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: small in-order FIFO of {pc, ins, adel}
// with valid/ready on both sides and a single-cycle flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_ins,
  input  logic                     in_adel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_ins,
  output logic                     out_adel,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t         mem [DEPTH];
  fetch_entry_t         head_entry;
  fetch_entry_t         out_entry;
  logic [AW-1:0]        head;
  logic [AW-1:0]        tail;
  logic [CW-1:0]        cnt;
  logic                 push;
  logic                 pop;

  // in_ready looks only at registered occupancy, never at out_ready.
  assign in_ready  = (cnt != FULL_CNT);
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{pc: in_pc, ins: in_ins, adel: in_adel};
  end

  assign head_entry = mem[head];

  always_comb begin
    out_entry = NOP_ENTRY;
    if (out_valid) out_entry = head_entry;
  end

  assign out_pc   = out_entry.pc;
  assign out_ins  = out_entry.ins;
  assign out_adel = out_entry.adel;

endmodule
